// File: rtl/ga_chrom_trans_gen.sv
// ---------------------------------------------------------------------------
// ga_chrom_trans_gen
//   Turns one GA chromosome into a burst of TRANS_COUNT ALU transactions.
//   Every field (delay, REG_A, REG_B, IMM, MEM) has one weight per value
//   range. A range is chosen by weighted rejection sampling on a 64-bit
//   LFSR, and the value is {range index, uniform low bits}.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   START           capture CHROM/SEED and begin a burst (ignored while BUSY)
//   CHROM           packed weights: delay field at the bottom, then A, B, IMM,
//                   MEM; range i of a field sits at field_base+WEIGHT_W*i
//   SEED            LFSR seed loaded on START, 0 selects LFSR_SEED
//   BUSY            burst in progress
//   DONE            one-cycle pulse after the last transfer
//   OP, MOVI        opcode and operand-select code
//   REG_A, REG_B,
//   IMM, MEM        operands
//   VLD / RDY       valid/ready handshake towards the ALU driver
// ---------------------------------------------------------------------------

// Weighted range picker for one field. Accepts when r falls below the field
// total; a field with no weight at all picks its range uniformly from r.
module ga_range_sel #(
   parameter int R  = 8,
   parameter int WW = 4,
   parameter int RW = 7,
   parameter int IW = 3
) (
   input  logic [R*WW-1:0] w_i,
   input  logic [RW-1:0]   r_i,
   output logic            hit_o,
   output logic [IW-1:0]   idx_o
);
   localparam int IB = $clog2(R);

   logic [RW-1:0] total;
   logic [RW-1:0] cum;

   always_comb begin
      total = '0;
      for (int i = 0; i < R; i++) total = total + RW'(w_i[i*WW +: WW]);
   end

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      cum   = '0;
      if (total == '0) begin
         // top log2(R) bits of r; collapses to 0 when R == 1
         hit_o = 1'b1;
         idx_o = IW'(r_i >> (RW - IB));
      end else begin
         // first range whose running weight sum exceeds r
         for (int i = 0; i < R; i++) begin
            cum = cum + RW'(w_i[i*WW +: WW]);
            if (!hit_o && (r_i < cum)) begin
               hit_o = 1'b1;
               idx_o = IW'(i);
            end
         end
      end
   end
endmodule

module ga_chrom_trans_gen #(
   parameter int          DATA_WIDTH   = 8,
   parameter int          DELAY_WIDTH  = 4,
   parameter int          DELAY_RANGES = 4,
   parameter int          OP_RANGES    = 8,
   parameter int          WEIGHT_W     = 4,
   parameter int          TRANS_COUNT  = 2,
   parameter logic [63:0] LFSR_SEED    = 64'h1
) (
   input  logic                                           CLK,
   input  logic                                           RST,
   input  logic                                           START,
   input  logic [(DELAY_RANGES+4*OP_RANGES)*WEIGHT_W-1:0] CHROM,
   input  logic [63:0]                                    SEED,
   output logic                                           BUSY,
   output logic                                           DONE,
   output logic [3:0]                                     OP,
   output logic [1:0]                                     MOVI,
   output logic [DATA_WIDTH-1:0]                          REG_A,
   output logic [DATA_WIDTH-1:0]                          REG_B,
   output logic [DATA_WIDTH-1:0]                          MEM,
   output logic [DATA_WIDTH-1:0]                          IMM,
   output logic                                           VLD,
   input  logic                                           RDY
);
   localparam int CHROM_W = (DELAY_RANGES + 4*OP_RANGES) * WEIGHT_W;
   localparam int WMAX    = 2**WEIGHT_W - 1;
   localparam int FW_D    = DELAY_RANGES * WEIGHT_W;
   localparam int FW_O    = OP_RANGES * WEIGHT_W;
   // r width is just wide enough to cover the largest possible field total
   localparam int RW_D    = $clog2(DELAY_RANGES*WMAX + 1);
   localparam int RW_O    = $clog2(OP_RANGES*WMAX + 1);
   localparam int IB_D    = $clog2(DELAY_RANGES);
   localparam int IB_O    = $clog2(OP_RANGES);
   localparam int IW_D    = (IB_D > 0) ? IB_D : 1;
   localparam int IW_O    = (IB_O > 0) ? IB_O : 1;
   localparam int LW_D    = DELAY_WIDTH - IB_D;
   localparam int LW_O    = DATA_WIDTH - IB_O;
   // LFSR slice map: delay r, A/B/IMM/MEM r, A/B/IMM/MEM low, OP, MOVI, delay low
   localparam int P_OR    = RW_D;
   localparam int P_LO    = P_OR + 4*RW_O;
   localparam int P_OP    = P_LO + 4*LW_O;
   localparam int P_MV    = P_OP + 4;
   localparam int P_DL    = P_MV + 2;
   localparam int CW      = $clog2(TRANS_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DLY, S_SEND} state_t;

   state_t                               state_q, state_d;
   logic [63:0]                          lfsr_q, lfsr_d, lfsr_nx;
   logic [CHROM_W-1:0]                   chrom_q, chrom_d;
   logic [CW-1:0]                        cnt_q, cnt_d;
   logic [DELAY_WIDTH-1:0]               dcnt_q, dcnt_d;
   logic [4:0]                           acc_q, acc_d, acc_now;
   logic [IW_D-1:0]                      d_idx_q, d_idx_d, d_idx_now, d_idx;
   logic [3:0][IW_O-1:0]                 o_idx_q, o_idx_d, o_idx_now, o_idx;
   logic                                 d_hit;
   logic [3:0]                           o_hit;
   logic [DELAY_WIDTH-1:0]               d_val;
   logic [3:0][DATA_WIDTH-1:0]           o_val;
   logic [3:0][DATA_WIDTH-1:0]           p_val_q, p_val_d;
   logic [3:0]                           p_op_q, p_op_d;
   logic [1:0]                           p_mv_q, p_mv_d;
   logic [3:0][DATA_WIDTH-1:0]           out_q, out_d;
   logic [3:0]                           op_q, op_d;
   logic [1:0]                           mv_q, mv_d;
   logic                                 vld_q, vld_d, busy_q, busy_d, done_q, done_d;
   logic                                 all_acc, last;

   assign lfsr_nx = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
   assign last    = (cnt_q == CW'(TRANS_COUNT - 1));

   // ---------------- range pickers ----------------
   ga_range_sel #(.R(DELAY_RANGES), .WW(WEIGHT_W), .RW(RW_D), .IW(IW_D)) u_dsel (
      .w_i   (chrom_q[FW_D-1:0]),
      .r_i   (lfsr_q[RW_D-1:0]),
      .hit_o (d_hit),
      .idx_o (d_idx)
   );

   for (genvar f = 0; f < 4; f++) begin : g_fld
      ga_range_sel #(.R(OP_RANGES), .WW(WEIGHT_W), .RW(RW_O), .IW(IW_O)) u_osel (
         .w_i   (chrom_q[FW_D + f*FW_O +: FW_O]),
         .r_i   (lfsr_q[P_OR + f*RW_O +: RW_O]),
         .hit_o (o_hit[f]),
         .idx_o (o_idx[f])
      );
      if (IB_O > 0) begin : g_idx
         assign o_val[f] = {o_idx_now[f], lfsr_q[P_LO + f*LW_O +: LW_O]};
      end else begin : g_noidx
         assign o_val[f] = lfsr_q[P_LO + f*LW_O +: LW_O];
      end
   end

   if (IB_D > 0) begin : g_didx
      assign d_val = {d_idx_now, lfsr_q[P_DL +: LW_D]};
   end else begin : g_nodidx
      assign d_val = lfsr_q[P_DL +: LW_D];
   end

   // Fields already accepted keep their latched index; the rest use this
   // cycle's draw. Bit 0 is the delay field, bits 4:1 are A, B, IMM, MEM.
   always_comb begin
      acc_now   = acc_q | {o_hit, d_hit};
      d_idx_now = acc_q[0] ? d_idx_q : d_idx;
      o_idx_now = o_idx;
      for (int f = 0; f < 4; f++)
         if (acc_q[f+1]) o_idx_now[f] = o_idx_q[f];
   end

   assign all_acc = &acc_now;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (START) state_d = S_GEN;
         S_GEN:  if (all_acc) state_d = (d_val == '0) ? S_SEND : S_DLY;
         S_DLY:  if (dcnt_q <= DELAY_WIDTH'(1)) state_d = S_SEND;
         S_SEND: if (RDY) state_d = last ? S_IDLE : S_GEN;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Outputs only change when a transaction is presented, so they hold the
   // previous transaction while generating/delaying the next one.
   always_comb begin
      vld_d  = (state_d == S_SEND);
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_SEND) && RDY && last;
      out_d  = out_q;
      op_d   = op_q;
      mv_d   = mv_q;
      if (state_q == S_GEN && state_d == S_SEND) begin
         out_d = o_val;
         op_d  = lfsr_q[P_OP +: 4];
         mv_d  = lfsr_q[P_MV +: 2];
      end else if (state_q == S_DLY && state_d == S_SEND) begin
         out_d = p_val_q;
         op_d  = p_op_q;
         mv_d  = p_mv_q;
      end
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      lfsr_d  = lfsr_q;
      chrom_d = chrom_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      acc_d   = acc_q;
      d_idx_d = d_idx_q;
      o_idx_d = o_idx_q;
      p_val_d = p_val_q;
      p_op_d  = p_op_q;
      p_mv_d  = p_mv_q;
      case (state_q)
         S_IDLE: if (START) begin
            chrom_d = CHROM;
            lfsr_d  = (SEED == '0) ? LFSR_SEED : SEED;
            cnt_d   = '0;
            acc_d   = '0;
         end
         S_GEN: begin
            lfsr_d  = lfsr_nx;
            acc_d   = acc_now;
            d_idx_d = d_idx_now;
            o_idx_d = o_idx_now;
            if (all_acc) begin
               dcnt_d  = d_val;
               p_val_d = o_val;
               p_op_d  = lfsr_q[P_OP +: 4];
               p_mv_d  = lfsr_q[P_MV +: 2];
            end
         end
         S_DLY: dcnt_d = dcnt_q - DELAY_WIDTH'(1);
         S_SEND: if (RDY) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lfsr_q  <= LFSR_SEED;
         chrom_q <= '0;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         acc_q   <= '0;
         d_idx_q <= '0;
         o_idx_q <= '0;
         p_val_q <= '0;
         p_op_q  <= '0;
         p_mv_q  <= '0;
         out_q   <= '0;
         op_q    <= '0;
         mv_q    <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         chrom_q <= chrom_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         acc_q   <= acc_d;
         d_idx_q <= d_idx_d;
         o_idx_q <= o_idx_d;
         p_val_q <= p_val_d;
         p_op_q  <= p_op_d;
         p_mv_q  <= p_mv_d;
         out_q   <= out_d;
         op_q    <= op_d;
         mv_q    <= mv_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign VLD   = vld_q;
   assign OP    = op_q;
   assign MOVI  = mv_q;
   assign REG_A = out_q[0];
   assign REG_B = out_q[1];
   assign IMM   = out_q[2];
   assign MEM   = out_q[3];

endmodule

// File: doc/ga_chrom_trans_gen.md
Name: ga_chrom_trans_gen

Overview:
- Hardware stimulus generator that turns one GA chromosome into a burst of ALU input transactions for the DUT.
- Sits directly downstream of the GA test configuration and directly upstream of the ALU driver/DUT input port.
- The chromosome holds a weight for each value range of the delay and operand fields. The block picks a range per field by weighted rejection sampling from an LFSR, then draws a uniform value inside that range.

Parameters:
- DATA_WIDTH, 8, operand width (REG_A, REG_B, IMM, MEM).
- DELAY_WIDTH, 4, width of the inter-transaction delay.
- DELAY_RANGES, 4, number of delay ranges; power of 2 or 1.
- OP_RANGES, 8, number of ranges per operand field; power of 2 or 1.
- WEIGHT_W, 4, width of each range weight.
- TRANS_COUNT, 2, transactions emitted per chromosome.
- LFSR_SEED, 64'h1, LFSR reset and fallback seed; must be nonzero.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  capture CHROM/SEED and begin a burst; ignored while BUSY.
- CHROM  in  (DELAY_RANGES+4*OP_RANGES)*WEIGHT_W = 144  packed weights.
  - [15:0] delay ranges, [47:16] A, [79:48] B, [111:80] IMM, [143:112] MEM.
  - Range i of a field sits at field_base+WEIGHT_W*i.
- SEED  in  64  LFSR seed loaded on START; 0 means use LFSR_SEED.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse after the last transfer.
- OP  out  4  ALU opcode.
- MOVI  out  2  operand-select code.
- REG_A, REG_B, MEM, IMM  out  DATA_WIDTH each  operands.
- VLD  out  1  transaction valid.
- RDY  in  1  downstream ready.

Behaviour:
- Reset (async, RST=1): all outputs 0, FSM=IDLE, LFSR=LFSR_SEED, transaction counter 0, chromosome register 0. Reset mid-burst aborts immediately, with no DONE.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60. Advances once per cycle in GEN only.
- Slices for default parameters:
  - Delay: [5:0] delay r, [61:60] delay low bits.
  - Range draws: [12:6] A r, [19:13] B r, [26:20] IMM r, [33:27] MEM r.
  - Value low bits: [38:34] A low, [43:39] B low, [48:44] IMM low, [53:49] MEM low.
  - Control: [57:54] OP, [59:58] MOVI.
- Per field: total = sum of its weights, computed on the captured chromosome.
- Range selection (GEN, all fields in parallel, each cycle):
  - If total=0, idx = top log2(R) bits of r, accepted at once.
  - Else, if r < total, idx = smallest i with cumulative weight(0..i) > r; accepted and latched.
  - Else reject and retry next cycle.
- Value formation: value = {idx, low bits}, so range i covers [i*2^W/R, (i+1)*2^W/R-1]. Low bits, OP and MOVI are latched in the cycle the last field is accepted.
- FSM:
  - IDLE: on START, capture CHROM; load LFSR from SEED (or LFSR_SEED if SEED=0); BUSY=1; counter=0; go to GEN.
  - GEN: stay until every field is accepted, then go to DELAY with dcnt=delay value. A delay value of 0 goes straight to SEND.
  - DELAY: decrement dcnt each cycle; at dcnt=1 go to SEND. A delay value d gives exactly d idle cycles between GEN exit and VLD rise.
  - SEND: VLD=1 and outputs stable until VLD&RDY.
    - On a transfer, counter++.
    - If counter reaches TRANS_COUNT: VLD=0, DONE=1 for one cycle, BUSY=0, go to IDLE.
    - Otherwise go to GEN, with VLD low in that cycle.
- Minimum latency START→first VLD is 2 cycles, with every field accepted on the first try and delay 0.
- Outputs hold their last values when VLD=0.
- START together with the final transfer is ignored.

Test Plan:
- A weights only range 5 (w=15), others only range 0, delay only range 0, TRANS_COUNT=2, RDY=1 → 2 transfers with REG_A in 160..191, REG_B/IMM/MEM in 0..31, delay 0..3, then DONE pulse and BUSY low next cycle.
- All-zero CHROM, SEED=0 → same result as SEED=LFSR_SEED; uniform range index, no GEN stall beyond 1 cycle per transaction.
- Single weight 1 on range 7 of MEM (total=1) → GEN stalls until MEM r=0; every MEM value is in 224..255; cycle count matches the reference model.
- RDY held low 10 cycles during SEND → VLD stays 1 and OP/MOVI/operands stay constant for all 10 cycles; transfer occurs on the cycle RDY rises.
- RST asserted two cycles after START → all outputs 0 asynchronously, no DONE; a new START afterwards reproduces the same sequence for the same SEED.
- START pulsed while BUSY → ignored; burst length stays TRANS_COUNT and the chromosome is unchanged.
